// File: rtl/rect_fill.sv
// Rectangle fill engine: writes a solid palette index into a linear frame buffer, one pixel per accepted write.
// Optional build macro RECT_FILL_CLIP_EN clips rectangles to the screen instead of rejecting them.
module rect_fill #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BPP      = 3,
    localparam int AW      = $clog2(H_ACTIVE * V_ACTIVE)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           cmd_valid_i,
    output logic           cmd_ready_o,
    input  logic [9:0]     cmd_x_i,
    input  logic [9:0]     cmd_y_i,
    input  logic [9:0]     cmd_w_i,
    input  logic [9:0]     cmd_h_i,
    input  logic [BPP-1:0] cmd_color_i,
    output logic           wr_en_o,
    output logic [AW-1:0]  wr_addr_o,
    output logic [BPP-1:0] wr_data_o,
    input  logic           wr_ready_i,
    output logic           busy_o,
    output logic           done_o,
    output logic           err_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_FILL  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [11:0] H_C    = 12'(H_ACTIVE);
    localparam logic [11:0] V_C    = 12'(V_ACTIVE);
    localparam logic [AW-1:0] H_AW = AW'(H_ACTIVE);

    logic [1:0]     state_q, state_d;
    logic [9:0]     x_q, x_d;
    logic [9:0]     y_q, y_d;
    logic [9:0]     w_q, w_d;
    logic [9:0]     h_q, h_d;
    logic [BPP-1:0] color_q, color_d;
    logic [AW-1:0]  row_base_q, row_base_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [9:0]     col_left_q, col_left_d;
    logic [9:0]     row_left_q, row_left_d;
    logic [9:0]     wm1_q, wm1_d;
    logic           rej_q, rej_d;

    logic [11:0]    x_ext, y_ext;
    logic [9:0]     w_eff, h_eff;
    logic           empty, reject;
    logic [AW-1:0]  base_calc;

`ifdef RECT_FILL_CLIP_EN
    logic           off_screen;
    logic [11:0]    x_room, y_room;
`else
    logic [11:0]    x_end, y_end;
    logic           zero_size;
`endif

    // Geometry evaluated from the latched command during SETUP.
    always_comb begin
        x_ext     = {2'b00, x_q};
        y_ext     = {2'b00, y_q};
        base_calc = AW'(y_q) * H_AW + AW'(x_q);
`ifdef RECT_FILL_CLIP_EN
        off_screen = (x_ext >= H_C) || (y_ext >= V_C);
        x_room     = H_C - x_ext;
        y_room     = V_C - y_ext;
        // Room is only taken when smaller than the 10-bit request, so it fits.
        w_eff      = ({2'b00, w_q} > x_room) ? x_room[9:0] : w_q;
        h_eff      = ({2'b00, h_q} > y_room) ? y_room[9:0] : h_q;
        reject     = 1'b0;
        empty      = off_screen || (w_eff == '0) || (h_eff == '0);
`else
        x_end      = x_ext + {2'b00, w_q};
        y_end      = y_ext + {2'b00, h_q};
        w_eff      = w_q;
        h_eff      = h_q;
        zero_size  = (w_q == '0) || (h_q == '0);
        reject     = !zero_size && ((x_end > H_C) || (y_end > V_C));
        empty      = zero_size || reject;
`endif
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        w_d        = w_q;
        h_d        = h_q;
        color_d    = color_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        col_left_d = col_left_q;
        row_left_d = row_left_q;
        wm1_d      = wm1_q;
        rej_d      = rej_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    x_d     = cmd_x_i;
                    y_d     = cmd_y_i;
                    w_d     = cmd_w_i;
                    h_d     = cmd_h_i;
                    color_d = cmd_color_i;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                rej_d      = reject;
                row_base_d = base_calc;
                addr_d     = base_calc;
                col_left_d = w_eff - 10'd1;
                wm1_d      = w_eff - 10'd1;
                row_left_d = h_eff - 10'd1;
                state_d    = empty ? S_DONE : S_FILL;
            end
            S_FILL: begin
                if (wr_ready_i) begin
                    if (col_left_q == '0) begin
                        if (row_left_q == '0) begin
                            state_d = S_DONE;
                        end else begin
                            // Next row base is an add of the line pitch, no multiply.
                            row_left_d = row_left_q - 10'd1;
                            col_left_d = wm1_q;
                            row_base_d = row_base_q + H_AW;
                            addr_d     = row_base_q + H_AW;
                        end
                    end else begin
                        col_left_d = col_left_q - 10'd1;
                        addr_d     = addr_q + AW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            w_q        <= '0;
            h_q        <= '0;
            color_q    <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            col_left_q <= '0;
            row_left_q <= '0;
            wm1_q      <= '0;
            rej_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            w_q        <= w_d;
            h_q        <= h_d;
            color_q    <= color_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            col_left_q <= col_left_d;
            row_left_q <= row_left_d;
            wm1_q      <= wm1_d;
            rej_q      <= rej_d;
        end
    end

    // Reset masks every output in the reset cycle itself, so nothing is written while rst_i is high.
    assign cmd_ready_o = (state_q == S_IDLE) && !rst_i;
    assign busy_o      = (state_q != S_IDLE) && !rst_i;
    assign wr_en_o     = (state_q == S_FILL) && !rst_i;
    assign wr_addr_o   = rst_i ? '0 : addr_q;
    assign wr_data_o   = rst_i ? '0 : color_q;
    assign done_o      = (state_q == S_DONE) && !rst_i;
    assign err_o       = (state_q == S_DONE) && rej_q && !rst_i;

endmodule

// File: tb/tb_rect_fill.sv
// Directed, table-driven bench for rect_fill with hand-computed write addresses and latencies.
module tb_rect_fill;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_x, cmd_y, cmd_w, cmd_h;
    logic [2:0]  cmd_color;
    logic        wr_en;
    logic [18:0] wr_addr;
    logic [2:0]  wr_data;
    logic        wr_ready;
    logic        busy, done, err;

    int tests_run = 0;
    int fails     = 0;

    always #5 clk = ~clk;

    rect_fill #(.H_ACTIVE(640), .V_ACTIVE(480), .BPP(3)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_x_i     (cmd_x),
        .cmd_y_i     (cmd_y),
        .cmd_w_i     (cmd_w),
        .cmd_h_i     (cmd_h),
        .cmd_color_i (cmd_color),
        .wr_en_o     (wr_en),
        .wr_addr_o   (wr_addr),
        .wr_data_o   (wr_data),
        .wr_ready_i  (wr_ready),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    typedef struct {
        int x, y, w, h, c;
        int si, sn;          // stall on write index si for sn cycles (si = -1: none)
        int n, lat, err;     // expected write count, accept->done cycles, err flag
        logic [7:0][31:0] a; // expected addresses in order
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(int x, int y, int w, int h, int c, int si, int sn,
                                int n, int lat, int e,
                                int a0, int a1, int a2, int a3,
                                int a4, int a5, int a6, int a7);
        vec_t v;
        v.x = x; v.y = y; v.w = w; v.h = h; v.c = c;
        v.si = si; v.sn = sn; v.n = n; v.lat = lat; v.err = e;
        v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
        v.a[4] = a4; v.a[5] = a5; v.a[6] = a6; v.a[7] = a7;
        return v;
    endfunction

    task automatic drive_cmd(input int x, input int y, input int w, input int h, input int c);
        cmd_x     = 10'(x);
        cmd_y     = 10'(y);
        cmd_w     = 10'(w);
        cmd_h     = 10'(h);
        cmd_color = 3'(c);
        cmd_valid = 1'b1;
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        int  nw;
        int  stalled;
        int  exp_a;
        bit  fin;
        nw = 0; stalled = 0; fin = 0;
        @(negedge clk);
        for (int i = 0; i < 20 && cmd_ready !== 1'b1; i++) @(negedge clk);
        chk({nm, " ready"}, int'(cmd_ready), 1);
        wr_ready = 1'b1;
        drive_cmd(v.x, v.y, v.w, v.h, v.c);
        for (int k = 1; k <= 60 && !fin; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (k == 1) chk({nm, " busy"}, int'(busy), 1);
            if (wr_en) begin
                exp_a = (nw < v.n && nw < 8) ? int'(v.a[nw]) : -1;
                chk({nm, " addr"}, int'(wr_addr), exp_a);
                chk({nm, " data"}, int'(wr_data), v.c);
                if (nw == v.si && stalled < v.sn) begin
                    wr_ready = 1'b0;
                    stalled++;
                end else begin
                    wr_ready = 1'b1;
                    nw++;
                end
            end else begin
                wr_ready = 1'b1;
            end
            if (done) begin
                chk({nm, " latency"}, k, v.lat);
                chk({nm, " err"}, int'(err), v.err);
                chk({nm, " writes"}, nw, v.n);
                chk({nm, " wr_en in done"}, int'(wr_en), 0);
                fin = 1;
            end else if (err) begin
                chk({nm, " err without done"}, 1, 0);
            end
        end
        if (!fin) chk({nm, " timeout"}, 0, 1);
        wr_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; wr_ready = 1'b1;
        cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;

        vecs[0] = mk(2, 1, 3, 2, 5, -1, 0, 6, 8, 0, 642, 643, 644, 1282, 1283, 1284, 0, 0);
        vecs[1] = mk(2, 1, 3, 2, 5, 1, 3, 6, 11, 0, 642, 643, 644, 1282, 1283, 1284, 0, 0);
        vecs[2] = mk(2, 1, 3, 2, 5, 3, 1, 6, 9, 0, 642, 643, 644, 1282, 1283, 1284, 0, 0);
`ifdef RECT_FILL_CLIP_EN
        vecs[3] = mk(638, 479, 4, 3, 3, -1, 0, 2, 4, 0, 307198, 307199, 0, 0, 0, 0, 0, 0);
        vecs[4] = mk(640, 0, 5, 5, 6, -1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`else
        vecs[3] = mk(638, 479, 4, 3, 3, -1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[4] = mk(640, 0, 5, 5, 6, -1, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
`endif
        vecs[5] = mk(5, 5, 0, 10, 2, -1, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[6] = mk(637, 0, 3, 2, 1, -1, 0, 6, 8, 0, 637, 638, 639, 1277, 1278, 1279, 0, 0);
        vecs[7] = mk(0, 478, 1, 2, 2, -1, 0, 2, 4, 0, 305920, 306560, 0, 0, 0, 0, 0, 0);
        vecs[8] = mk(0, 0, 8, 1, 4, 0, 2, 8, 12, 0, 0, 1, 2, 3, 4, 5, 6, 7);
        vecs[9] = mk(0, 0, 1, 1, 7, -1, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst cmd_ready", int'(cmd_ready), 0);
        chk("rst wr_en", int'(wr_en), 0);
        chk("rst wr_addr", int'(wr_addr), 0);
        chk("rst wr_data", int'(wr_data), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst err", int'(err), 0);
        rst = 1'b0;
        #1;
        chk("post-rst cmd_ready", int'(cmd_ready), 1);

        for (int i = 0; i < 10; i++) run_vec($sformatf("v%0d", i), vecs[i]);

        // Reset in the middle of a fill, after the second write completes
        @(negedge clk);
        wr_ready = 1'b1;
        drive_cmd(2, 1, 3, 2, 5);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (k == 2) chk("mid-rst w0 addr", int'(wr_addr), 642);
            if (k == 3) chk("mid-rst w1 addr", int'(wr_addr), 643);
            if (k == 4) begin
                rst = 1'b1;
                #1;
                chk("mid-rst wr_en in reset", int'(wr_en), 0);
                chk("mid-rst ready in reset", int'(cmd_ready), 0);
            end
            if (k == 5) begin
                rst = 1'b0;
                #1;
                chk("mid-rst ready after", int'(cmd_ready), 1);
                chk("mid-rst busy after", int'(busy), 0);
            end
            if (k >= 5) begin
                chk("mid-rst no write", int'(wr_en), 0);
                chk("mid-rst no done", int'(done), 0);
            end
        end
        run_vec("post-rst 1x1", vecs[9]);

        // Two commands queued back to back with cmd_valid held high
        @(negedge clk);
        wr_ready = 1'b1;
        drive_cmd(0, 0, 2, 1, 1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) drive_cmd(0, 1, 1, 1, 2);
            if (k == 6) cmd_valid = 1'b0;
            chk($sformatf("q ready k%0d", k), int'(cmd_ready), (k == 5) ? 1 : 0);
            chk($sformatf("q done k%0d", k), int'(done), (k == 4 || k == 8) ? 1 : 0);
            chk($sformatf("q wr_en k%0d", k), int'(wr_en), (k == 2 || k == 3 || k == 7) ? 1 : 0);
            if (k == 2) chk("q A addr0", int'(wr_addr), 0);
            if (k == 3) chk("q A addr1", int'(wr_addr), 1);
            if (k == 7) begin
                chk("q B addr", int'(wr_addr), 640);
                chk("q B data", int'(wr_data), 2);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
